instr_fetch_unit: RTL and testbench

//  Instruction fetch front end that produces the 32-bit instr stream consumed by controlunit.

---
 rtl/instr_fetch_unit.sv | 201 ++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : PC, 1-cycle imem request/response, instruction FIFO and a
//            registered valid/ready output stage with branch redirect flush.
// Options  : IFU_PERF_EN adds perf_fetch_cnt / perf_flush_cnt ports.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int              c_ptr_w = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int              c_cnt_w = $clog2(BUF_DEPTH + 1);
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(BUF_DEPTH);
    localparam logic [31:0]     c_nop   = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [31:0]          r_pc;
    logic                 r_inflight;
    logic [31:0]          r_inflight_pc;

    logic                 r_out_valid;
    logic [31:0]          r_out_instr;
    logic [31:0]          r_out_pc;

    logic [31:0]          r_fifo_instr [BUF_DEPTH];
    logic [31:0]          r_fifo_pc    [BUF_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;

    logic                 w_fetch_state;
    logic [c_cnt_w:0]     w_occupancy;
    logic                 w_accept;
    logic                 w_resp;
    logic                 w_out_free;
    logic                 w_fifo_empty;
    logic                 w_fifo_pop;
    logic                 w_fifo_push;

    // Occupancy uses the registered count: a same-cycle pop never frees a slot.
    assign w_fetch_state = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_occupancy   = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_inflight};
    assign imem_req      = w_fetch_state && !redirect && (w_occupancy < c_depth);
    assign imem_addr     = r_pc;
    assign w_accept      = imem_req && imem_gnt;

    // Responses are wrong-path when a redirect lands on them or while draining.
    assign w_resp        = r_inflight && !redirect && (r_state != ST_DRAIN);
    assign w_out_free    = !r_out_valid || instr_ready;
    assign w_fifo_empty  = (r_count == '0);
    assign w_fifo_pop    = w_out_free && !w_fifo_empty && !redirect;
    assign w_fifo_push   = w_resp && !(w_out_free && w_fifo_empty);

    assign instr_valid   = r_out_valid;
    assign instr         = r_out_instr;
    assign instr_pc      = r_out_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WAIT:  w_state_next = ST_RUN;
            ST_RUN:   w_state_next = (redirect && r_inflight) ? ST_DRAIN : ST_RUN;
            ST_DRAIN: w_state_next = redirect ? ST_DRAIN : ST_RUN;
            default:  w_state_next = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC & 32'hFFFF_FFFC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) begin
                r_inflight_pc <= r_pc;
            end
            if (redirect) begin
                r_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    // Output stage is the architectural FIFO head; the response bypasses
    // the buffer when both are empty so an accept at N is visible at N+2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= c_nop;
            r_out_pc    <= '0;
        end else if (redirect) begin
            r_out_valid <= 1'b0;
        end else if (w_out_free) begin
            if (w_fifo_pop) begin
                r_out_valid <= 1'b1;
                r_out_instr <= r_fifo_instr[r_rd_ptr];
                r_out_pc    <= r_fifo_pc[r_rd_ptr];
            end else if (w_resp) begin
                r_out_valid <= 1'b1;
                r_out_instr <= imem_rdata;
                r_out_pc    <= r_inflight_pc;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fifo_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_fifo_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_fifo_push, w_fifo_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_fifo_push) begin
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

`ifdef IFU_PERF_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (redirect) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// Testbench for instr_fetch_unit: vector table, directed corner sequences and
// randomized traffic checked against an expected-PC stream model.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        rst2_n = 1'b0;
    logic        req2;
    logic [31:0] addr2;
    logic        gnt2 = 1'b1;
    logic [31:0] rdata2 = 32'h0;
    logic        redir2 = 1'b0;
    logic [31:0] rpc2 = 32'h0;
    logic        valid2;
    logic        ready2 = 1'b1;
    logic [31:0] instr2;
    logic [31:0] pc2;

`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf2_fetch, perf2_flush;
`endif

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef IFU_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2), .imem_rdata(rdata2),
        .redirect(redir2), .redirect_pc(rpc2),
        .instr_valid(valid2), .instr_ready(ready2), .instr(instr2), .instr_pc(pc2)
`ifdef IFU_PERF_EN
        , .perf_fetch_cnt(perf2_fetch), .perf_flush_cnt(perf2_flush)
`endif
    );

    // Memory models: word at address a is a ^ salt, garbage when nothing accepted.
    logic [31:0] salt = 32'h0;
    always @(posedge clk) begin
        rdata2 <= (req2 && gnt2) ? addr2 : 32'hDEAD_BEEF;
        imem_rdata <= (imem_req && imem_gnt) ? (imem_addr ^ salt) : 32'hDEAD_BEEF;
    end

    int n_checks = 0;
    int n_err    = 0;
    int pops     = 0;

    logic [31:0] exp_pc = 32'h0;
    logic        p_redir = 1'b0, p_stall = 1'b0, p_hold = 1'b0;
    logic [31:0] p_addr = 32'h0, p_pc = 32'h0, p_instr = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Stream/protocol model: delivered PCs follow the sequential/redirect rules.
    task automatic monitor();
        if (p_redir) chk("flush_valid", 32'(instr_valid), 32'd0);
        if (p_stall && !redirect) begin
            chk("stall_req", 32'(imem_req), 32'd1);
            chk("stall_addr", imem_addr, p_addr);
        end
        if (p_hold) begin
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_pc", instr_pc, p_pc);
            chk("hold_instr", instr, p_instr);
        end
        if (instr_valid && instr_ready) begin
            chk("stream_pc", instr_pc, exp_pc);
            chk("stream_instr", instr, exp_pc ^ salt);
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
        p_redir = redirect;
        p_stall = imem_req && !imem_gnt;
        p_addr  = imem_addr;
        p_hold  = instr_valid && !instr_ready && !redirect;
        p_pc    = instr_pc;
        p_instr = instr;
    endtask

    task automatic step(input logic g, input logic r, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        imem_gnt = g; instr_ready = r; redirect = rd; redirect_pc = rpc;
        #1;
        monitor();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; imem_gnt = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
`ifdef IFU_PERF_EN
        chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("rst_perf_flush", perf_flush_cnt, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("wait_req", 32'(imem_req), 32'd0);
        exp_pc = 32'h0; p_redir = 1'b0; p_stall = 1'b0; p_hold = 1'b0;
    endtask

    typedef struct {
        logic        g;
        logic        r;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
        logic        nop;
    } vec_t;

    vec_t tbl [16];

    logic [31:0] q2 [$];
    int          pops0;

    initial begin
        // Reset release into steady streaming, then a 6-cycle consumer stall.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  1'b1};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0,  1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0,  1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4,  1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8,  1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'd20, 1'b1, 32'd12, 1'b0};
        for (int i = 6; i <= 10; i++)
            tbl[i] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'd12, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 32'd12, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 32'd24, 1'b1, 32'd16, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 32'd28, 1'b1, 32'd20, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 32'd32, 1'b1, 32'd24, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 32'd36, 1'b1, 32'd28, 1'b0};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].g, tbl[i].r, 1'b0, 32'h0);
            chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
            if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].v));
            if (tbl[i].v) begin
                chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].pc);
                chk($sformatf("tbl%0d_instr", i), instr, tbl[i].pc);
            end
            if (tbl[i].nop) begin
                chk($sformatf("tbl%0d_nop", i), instr, NOP);
                chk($sformatf("tbl%0d_nop_pc", i), instr_pc, 32'h0);
            end
        end
`ifdef IFU_PERF_EN
        chk("perf_fetch_tbl", perf_fetch_cnt, 32'd9);
        chk("perf_flush_tbl", perf_flush_cnt, 32'd0);
`endif

        // Reset mid-stream: outputs drop at once.
        chk("pre_reset_valid", 32'(instr_valid), 32'd1);
        do_reset();

        // Redirect with one in output stage, one buffered, one in flight.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0103);
        chk("redir_req", 32'(imem_req), 32'd0);
        chk("redir_head_pc", instr_pc, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_tgt_req", 32'(imem_req), 32'd1);
        chk("redir_tgt_addr", imem_addr, 32'h0000_0100);
`ifdef IFU_PERF_EN
        chk("perf_flush_one", perf_flush_cnt, 32'd1);
`endif
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_gap_valid", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_tgt_valid", 32'(instr_valid), 32'd1);
        chk("redir_tgt_pc", instr_pc, 32'h0000_0100);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_next_pc", instr_pc, 32'h0000_0104);

        // Grant toggling 1,0,0,1: address held, stream contiguous.
        do_reset();
        pops0 = pops;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("gnt_hold_addr_a", imem_addr, 32'd4);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("gnt_hold_addr_b", imem_addr, 32'd4);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("gnt_resume_addr", imem_addr, 32'd4);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("gnt_pop_count", 32'(pops - pops0), 32'd6);

        // Wrapping reset PC on the second instance.
        @(negedge clk);
        rst2_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (valid2) begin
                q2.push_back(pc2);
                chk("wrap_instr", instr2, pc2);
            end
        end
        chk("wrap_count", 32'(q2.size()), 32'd6);
        if (q2.size() >= 4) begin
            chk("wrap_pc0", q2[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", q2[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", q2[2], 32'h0000_0000);
            chk("wrap_pc3", q2[3], 32'h0000_0004);
        end

        // Randomized traffic against the stream model.
        salt = 32'h5A5A_C3C3;
        do_reset();
        pops0 = pops;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75,
                 $urandom_range(0, 99) < 4, $urandom);
        end
        chk("rand_progress", 32'((pops - pops0) >= 300), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
